// File: rtl/flash_sample_reader_pkg.sv
// Shared types and defaults for the flash sample reader.
package flash_sample_reader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ        = 3'd1,
    WAIT_DATA  = 3'd2,
    OUT_FIRST  = 3'd3,
    WAIT_TICK  = 3'd4,
    OUT_SECOND = 3'd5
  } state_t;

  typedef logic signed [15:0] sample_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/flash_read_timeout.sv
// Read-data watchdog: a down-counter reloaded whenever the reader is not
// waiting for data, flagging expiry on terminal count.
module flash_read_timeout
  import flash_sample_reader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Reload while idle so each wait starts a fresh TIMEOUT_CYCLES window.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit word from flash per two sample ticks and plays it out as
// two signed 16-bit samples, half-word order chosen by playback direction.
// Optional build macro FLASH_READ_TIMEOUT_EN adds a read-data watchdog and
// a timeout output.
//
// state      | meaning
// IDLE       | waiting for tick to start a word fetch
// REQ        | Avalon read asserted, waiting out waitrequest
// WAIT_DATA  | read accepted, waiting for readdatavalid
// OUT_FIRST  | first half-word presented (sample_valid high)
// WAIT_TICK  | waiting for tick to present second half-word
// OUT_SECOND | second half-word presented, change pulsed
module flash_sample_reader
  import flash_sample_reader_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [ADDR_W-1:0] address,
  input  logic              forward,
  output logic              change,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output sample_t           sample,
  output logic              sample_valid,
  output logic              overrun
`ifdef FLASH_READ_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  state_t  state, state_n;
  sample_t other_half;

  logic ld_addr;
  logic capture;
  logic to_hit;
  logic play_second;
  logic tick_drop;
  logic expired;

`ifdef FLASH_READ_TIMEOUT_EN
  flash_read_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (state == WAIT_DATA),
    .expired(expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode plus single-cycle datapath strobes.
  always_comb begin
    state_n     = state;
    ld_addr     = 1'b0;
    capture     = 1'b0;
    to_hit      = 1'b0;
    play_second = 1'b0;
    tick_drop   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          ld_addr = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        tick_drop = tick;
        if (!flash_waitrequest) state_n = WAIT_DATA;
      end
      WAIT_DATA: begin
        tick_drop = tick;
        if (flash_readdatavalid) begin
          capture = 1'b1;
          state_n = OUT_FIRST;
        end else if (expired) begin
          to_hit  = 1'b1;
          state_n = OUT_FIRST;
        end
      end
      OUT_FIRST: begin
        tick_drop = tick;
        state_n   = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) begin
          play_second = 1'b1;
          state_n     = OUT_SECOND;
        end
      end
      OUT_SECOND: begin
        tick_drop = tick;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs; the second half-word is parked so direction changes
  // after capture cannot reorder the pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_read    <= 1'b0;
      flash_address <= '0;
      sample        <= '0;
      other_half    <= '0;
      sample_valid  <= 1'b0;
      change        <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      flash_read   <= (state_n == REQ);
      sample_valid <= capture | to_hit | play_second;
      change       <= play_second;
      overrun      <= tick_drop;
      if (ld_addr) flash_address <= address;
      if (capture) begin
        sample     <= forward ? sample_t'(flash_readdata[15:0]) : sample_t'(flash_readdata[31:16]);
        other_half <= forward ? sample_t'(flash_readdata[31:16]) : sample_t'(flash_readdata[15:0]);
      end else if (to_hit) begin
        sample     <= '0;
        other_half <= '0;
      end else if (play_second) begin
        sample <= other_half;
      end
    end
  end

`ifdef FLASH_READ_TIMEOUT_EN
  // Timeout pulse coincides with the substituted zero sample.
  always_ff @(posedge clk) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= to_hit;
  end
`endif

endmodule
